// File: rtl/muxn_rr.sv
// muxn_rr: N-channel, W-bit registered multiplexer with valid/ready on every port.
// Grants one input per cycle, either by fixed select or by round-robin arbitration.
module muxn_rr #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nxt;
  logic [SELW-1:0] rr_gnt;
  logic            rr_hit;
  logic [SELW-1:0] gnt;
  logic            gnt_ok;
  logic            sel_ok;
  logic            acc;
  logic            xfer;

  // Round-robin search: first valid channel starting at ptr, wrapping past NCH-1.
  always_comb begin
    int unsigned idx;
    logic [SELW-1:0] c;
    rr_gnt = '0;
    rr_hit = 1'b0;
    idx    = 0;
    c      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      c = SELW'(idx);
      if (!rr_hit && in_valid[c]) begin
        rr_hit = 1'b1;
        rr_gnt = c;
      end
    end
  end

  always_comb begin
    acc    = !out_valid || out_ready;
    sel_ok = (32'(sel) < NCH);
    if (mode) begin
      gnt    = rr_gnt;
      gnt_ok = rr_hit;
    end else begin
      gnt    = sel;
      gnt_ok = sel_ok;
    end
    // rst_n gating keeps every ready low while reset is asserted.
    in_ready = '0;
    if (acc && gnt_ok && rst_n) in_ready[gnt] = 1'b1;
    xfer    = |(in_ready & in_valid);
    ptr_nxt = (32'(gnt) == NCH - 1) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out       <= in[gnt*WIDTH +: WIDTH];
      out_ch    <= gnt;
      out_valid <= 1'b1;
      if (mode) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_rr.sv
// Self-checking bench for muxn_rr: directed test-plan steps plus randomized traffic
// compared against a behavioural grant/register model.
module tb_muxn_rr;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         mode;
  logic [1:0]   sel;
  logic [127:0] din;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  out;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;

  logic         mode3;
  logic [1:0]   sel3;
  logic [23:0]  din3;
  logic [2:0]   v3;
  logic [2:0]   rdy3;
  logic [7:0]   out3;
  logic         ov3;
  logic         ordy3;
  logic [1:0]   och3;

  int checks = 0;
  int errors = 0;

  logic [31:0]  m_out;
  bit           m_vld;
  int           m_ch;
  int           m_ptr;

  muxn_rr #(.NCH(4), .WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in(din),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  muxn_rr #(.NCH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in(din3),
    .in_valid(v3), .in_ready(rdy3), .out(out3), .out_valid(ov3),
    .out_ready(ordy3), .out_ch(och3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Grant rule: -1 means no channel may be granted this cycle.
  function automatic int ref_grant(int n, bit md, int s, int p, logic [3:0] v, bit acc);
    if (!acc) return -1;
    if (!md) return (s < n) ? s : -1;
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    m_out = '0; m_vld = 0; m_ch = 0; m_ptr = 0;
  endtask

  // Apply inputs after a falling edge, check ready, clock once, check registers.
  task automatic step(input bit md, input int s, input logic [127:0] d,
                      input logic [3:0] v, input bit ordy);
    int g;
    logic [3:0] exp_rdy;
    mode = md; sel = 2'(s); din = d; in_valid = v; out_ready = ordy;
    #1;
    g = ref_grant(4, md, s, m_ptr, v, !m_vld || ordy);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (g >= 0 && v[g]) begin
      m_out = d[g*32 +: 32];
      m_ch  = g;
      m_vld = 1;
      if (md) m_ptr = (g + 1) % 4;
    end else if (ordy) begin
      m_vld = 0;
    end
    #1;
    chk("out", 64'(out), 64'(m_out));
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_out", 64'(out), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [127:0] din_fix;
    logic [31:0]  t1_exp [4];
    din_fix = {32'h87654321, 32'h12345678, 32'h55555555, 32'hAAAAAAAA};
    t1_exp[0] = 32'hAAAAAAAA; t1_exp[1] = 32'h55555555;
    t1_exp[2] = 32'h12345678; t1_exp[3] = 32'h87654321;

    mode = 1'b1; sel = '0; din = din_fix; in_valid = 4'hF; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = '0; din3 = '0; v3 = '0; ordy3 = 1'b1;
    model_reset();

    // Reset state, with valid inputs present.
    #3;
    chk("init_out", 64'(out), 64'h0);
    chk("init_valid", 64'(out_valid), 64'h0);
    chk("init_ch", 64'(out_ch), 64'h0);
    chk("init_ready", 64'(in_ready), 64'h0);
    chk("init_valid3", 64'(ov3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed select, SEL stepped 0..3.
    for (int s = 0; s < 4; s++) begin
      step(0, s, din_fix, 4'hF, 1);
      chk("t1_out", 64'(out), 64'(t1_exp[s]));
      chk("t1_ch", 64'(out_ch), 64'(s));
    end

    // Round-robin from reset, all channels valid.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, din_fix, 4'hF, 1);
      chk("t2_ch", 64'(out_ch), 64'(i % 4));
    end

    // Skip and wrap: bring ptr to 3, then only channel 1 is valid.
    for (int i = 0; i < 3; i++) step(1, 0, din_fix, 4'hF, 1);
    step(1, 0, {32'h0, 32'h0, 32'hABCDEF01, 32'h0}, 4'b0010, 1);
    chk("t3_out", 64'(out), 64'hABCDEF01);
    chk("t3_ch", 64'(out_ch), 64'd1);
    step(1, 0, din_fix, 4'hF, 1);
    chk("t3_next", 64'(out_ch), 64'd2);

    // Backpressure holds FFFFFFFF, then same-cycle replace.
    step(0, 0, {96'h0, 32'hFFFFFFFF}, 4'hF, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), int'($urandom % 4), {$urandom, $urandom, $urandom, $urandom},
           4'($urandom), 0);
      chk("t4_hold", 64'(out), 64'hFFFFFFFF);
      chk("t4_ready", 64'(in_ready), 64'h0);
    end
    step(0, 2, {32'h0, 32'h10FEDCBA, 64'h0}, 4'hF, 1);
    chk("t4_replace", 64'(out), 64'h10FEDCBA);
    chk("t4_valid", 64'(out_valid), 64'h1);

    // Three-channel instance: out-of-range select and wrap at NCH-1.
    mode3 = 1'b0; sel3 = 2'd0; din3 = 24'h332211; v3 = 3'b111; ordy3 = 1'b0;
    #1 chk("t5_rdy_sel0", 64'(rdy3), 64'b001);
    @(posedge clk); #1;
    chk("t5_out", 64'(out3), 64'h11);
    chk("t5_valid", 64'(ov3), 64'h1);
    @(negedge clk);
    sel3 = 2'd3;
    #1 chk("t5_rdy_bp", 64'(rdy3), 64'b000);
    ordy3 = 1'b1;
    #1 chk("t5_rdy_oor", 64'(rdy3), 64'b000);
    @(posedge clk); #1;
    chk("t5_drain", 64'(ov3), 64'h0);
    chk("t5_hold", 64'(out3), 64'h11);
    @(negedge clk);
    mode3 = 1'b1; v3 = 3'b100;
    #1 chk("t5_rr_rdy", 64'(rdy3), 64'b100);
    @(posedge clk); #1;
    chk("t5_rr_ch", 64'(och3), 64'd2);
    chk("t5_rr_out", 64'(out3), 64'h33);
    @(negedge clk);
    v3 = 3'b111;
    #1 chk("t5_wrap_rdy", 64'(rdy3), 64'b001);
    @(posedge clk); #1;
    chk("t5_wrap_ch", 64'(och3), 64'd0);
    @(negedge clk);
    v3 = 3'b000;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), int'($urandom % 4), {$urandom, $urandom, $urandom, $urandom},
           4'($urandom), ($urandom % 4) != 0);

    // Reset mid-cycle while a word is pending.
    step(1, 0, din_fix, 4'hF, 0);
    chk("t6_pending", 64'(out_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out", 64'(out), 64'h0);
    chk("t6_valid", 64'(out_valid), 64'h0);
    chk("t6_ch", 64'(out_ch), 64'h0);
    chk("t6_ready", 64'(in_ready), 64'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, din_fix, 4'hF, 1);
    chk("t6_first", 64'(out_ch), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output. It generalises the 32-bit 4:1 select mux used in the datapath. It adds an output register and two selection modes: fixed select (SEL-driven) and fair round-robin arbitration. It sits between multiple producers and one consumer in the Proyecto_2 datapath and moves one word per cycle at full throughput.

## Interface
- NCH, 4: number of input channels (≥2)
- WIDTH, 32: data width in bits
- SELW, $clog2(NCH): width of SEL and OUT_CH
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- MODE  input  1  0 = fixed select by SEL, 1 = round-robin
- SEL  input  SELW  channel index used when MODE=0
- IN  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- IN_VALID  input  NCH  per-channel valid
- IN_READY  output  NCH  per-channel ready, combinational
- OUT  output  WIDTH  registered data
- OUT_VALID  output  1  OUT holds a word not yet consumed
- OUT_READY  input  1  consumer accepts OUT this cycle
- OUT_CH  output  SELW  index of the channel that supplied OUT

## Operation
- **Transfers.** An input transfer on channel i occurs when IN_VALID[i] && IN_READY[i]. An output transfer occurs when OUT_VALID && OUT_READY.
- **Accept condition.** ACC = !OUT_VALID || OUT_READY. This is a 1-entry pipeline register with no skid buffer.
- **Readiness.** At most one IN_READY bit is high in any cycle. The high bit is the granted channel G, and only when ACC=1.
- **MODE=0.**
  - G = SEL when SEL < NCH.
  - IN_READY[SEL] = ACC regardless of IN_VALID[SEL].
  - SEL ≥ NCH: all IN_READY=0, and no transfer occurs.
- **MODE=1.**
  - G is the first channel with IN_VALID=1, searching PTR, PTR+1, …, NCH-1, 0, …, PTR-1.
  - No valid channel: all IN_READY=0.
- **Round-robin pointer.**
  - PTR (SELW bits) updates only on an input transfer in MODE=1: PTR ← G+1, wrapping NCH-1 → 0.
  - PTR holds its value in MODE=0.
  - A change of MODE takes effect in the same cycle's grant. PTR is not reset by a MODE change.
- **Register update on input transfer.** OUT ← IN[G], OUT_CH ← G, OUT_VALID ← 1.
- **Register update without input transfer.** If OUT_READY=1, then OUT_VALID ← 0, while OUT and OUT_CH hold their values. Otherwise all output registers hold.
- **Simultaneous transfers.** An output transfer and an input transfer in the same cycle make the new word replace the old one, and OUT_VALID stays 1.
- **Stability under backpressure.** While OUT_VALID=1 && OUT_READY=0: OUT, OUT_CH and OUT_VALID are stable, and all IN_READY=0.

## Timing
- **Reset.** Asynchronous on RST_N low. OUT=0, OUT_VALID=0, OUT_CH=0, PTR=0. Outputs stay cleared while RST_N is low.
- **Reset mid-operation.** An in-flight word is discarded, and no IN_READY is asserted during reset. The first grant after release starts at channel 0.
- **Latency.** 1 cycle: a word accepted at edge k appears on OUT with OUT_VALID=1 after edge k.
- **Throughput.** 1 word/cycle when OUT_READY is held high.
- **Combinational paths.** OUT_READY, MODE, SEL and IN_VALID → IN_READY. There is no combinational path from any input to OUT, OUT_VALID or OUT_CH.
- **Fairness.** In MODE=1 with all channels continuously valid and OUT_READY=1, grants cycle 0,1,…,NCH-1,0. Any continuously valid channel is served within NCH transfers.

## Test plan
1. **Fixed select.** MODE=0, NCH=4, IN0..IN3 = AAAAAAAA / 55555555 / 12345678 / 87654321, all valid, OUT_READY=1, SEL stepped 0→3 one per cycle. Required: OUT shows AAAAAAAA, 55555555, 12345678, 87654321 each one cycle after its SEL; OUT_CH = 0..3.
2. **Round-robin.** MODE=1, all IN_VALID=1, OUT_READY=1 for 8 cycles after reset. Required: OUT_CH sequence 0,1,2,3,0,1,2,3; exactly one IN_READY high per cycle.
3. **Skip and wrap.** MODE=1, PTR=3, only IN_VALID[1]=1 with IN1=ABCDEF01. Required: grant 1, OUT=ABCDEF01, OUT_CH=1, next search starts at 2.
4. **Backpressure.** OUT_VALID=1 holding FFFFFFFF, OUT_READY=0 for 3 cycles while inputs change. Required: OUT stays FFFFFFFF, all IN_READY=0. Then OUT_READY=1 with IN2=10FEDCBA granted: same-cycle replace, OUT_VALID stays 1.
5. **Out-of-range select.** MODE=0, SEL=3 with NCH=3. Required: IN_READY=000, OUT_VALID falls to 0 after the pending word drains.
6. **Reset mid-operation.** RST_N pulsed low mid-cycle while OUT_VALID=1. Required: OUT=0, OUT_VALID=0, OUT_CH=0 immediately, without waiting for a clock edge; first grant after release is channel 0 in MODE=1.
